// File: rtl/jtdsp16_do_loop.sv
// rtl/jtdsp16_do_loop.sv - zero-overhead do/redo loop sequencer with instruction cache
module jtdsp16_do_loop #(
    parameter int CW = 15
) (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        do_start,
    input  logic [10:0] do_data,
    input  logic [15:0] rom_dout,
    output logic [15:0] cache_dout,
    output logic        up_xcache,
    output logic        loop_halt,
    output logic        loop_busy,
    output logic        do_err
);

    typedef enum logic [1:0] {IDLE, FILL, REPLAY} state_t;

    state_t      state, state_nxt;
    logic [3:0]  body_n, body_nxt;
    logic [3:0]  wr_ptr, wr_nxt;
    logic [3:0]  rd_ptr, rd_nxt;
    logic [6:0]  iter, iter_nxt;
    logic        err_nxt;
    logic [3:0]  req_n;
    logic [6:0]  req_k;
    logic        last_wr, last_rd;
    logic [15:0] cache [CW];

    assign req_n   = do_data[10:7];
    assign req_k   = do_data[6:0];
    assign last_wr = wr_ptr == body_n - 4'd1;
    assign last_rd = rd_ptr == body_n - 4'd1;

    always_comb begin
        state_nxt = state;
        body_nxt  = body_n;
        wr_nxt    = wr_ptr;
        rd_nxt    = rd_ptr;
        iter_nxt  = iter;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (do_start) begin
                    if (req_k == 7'd0) begin
                        err_nxt = 1'b1;
                    end else if (req_n != 4'd0) begin
                        body_nxt  = req_n;
                        iter_nxt  = req_k;
                        wr_nxt    = 4'd0;
                        state_nxt = FILL;
                    end else if (body_n != 4'd0) begin
                        iter_nxt  = req_k;
                        rd_nxt    = 4'd0;
                        state_nxt = REPLAY;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            FILL: begin
                // Nesting is not allowed: a do seen mid-loop is only flagged
                err_nxt = do_start;
                wr_nxt  = last_wr ? 4'd0 : wr_ptr + 4'd1;
                if (last_wr) begin
                    if (iter == 7'd1) begin
                        state_nxt = IDLE;
                    end else begin
                        iter_nxt  = iter - 7'd1;
                        rd_nxt    = 4'd0;
                        state_nxt = REPLAY;
                    end
                end
            end
            REPLAY: begin
                err_nxt = do_start;
                rd_nxt  = last_rd ? 4'd0 : rd_ptr + 4'd1;
                if (last_rd) begin
                    if (iter == 7'd1) state_nxt = IDLE;
                    else              iter_nxt  = iter - 7'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            body_n    <= 4'd0;
            iter      <= 7'd0;
            wr_ptr    <= 4'd0;
            rd_ptr    <= 4'd0;
            up_xcache <= 1'b0;
            loop_halt <= 1'b0;
            loop_busy <= 1'b0;
            do_err    <= 1'b0;
        end else if (cen) begin
            state     <= state_nxt;
            body_n    <= body_nxt;
            iter      <= iter_nxt;
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            up_xcache <= state_nxt == REPLAY;
            loop_halt <= state_nxt == REPLAY;
            loop_busy <= state_nxt != IDLE;
            do_err    <= err_nxt;
        end
    end

    // Cache contents survive reset; body_n==0 is what marks them stale
    always_ff @(posedge clk) begin
        if (cen && state == FILL) cache[wr_ptr] <= rom_dout;
    end

    assign cache_dout = (state == REPLAY) ? cache[rd_ptr] : 16'h0;

endmodule

// File: tb/tb_jtdsp16_do_loop.sv
// tb/tb_jtdsp16_do_loop.sv - scoreboard bench for jtdsp16_do_loop
module tb_jtdsp16_do_loop;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        do_start = 1'b0;
    logic [10:0] do_data = 11'd0;
    logic [15:0] rom_dout = 16'd0;
    logic [15:0] cache_dout;
    logic        up_xcache, loop_halt, loop_busy, do_err;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
    logic [15:0] model_cache [16];
    int          model_n = 0;

    jtdsp16_do_loop #(.CW(15)) dut (
        .rst        (rst),
        .clk        (clk),
        .cen        (cen),
        .do_start   (do_start),
        .do_data    (do_data),
        .rom_dout   (rom_dout),
        .cache_dout (cache_dout),
        .up_xcache  (up_xcache),
        .loop_halt  (loop_halt),
        .loop_busy  (loop_busy),
        .do_err     (do_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic c, input logic ds, input logic [10:0] dd, input logic [15:0] rw);
        cen      = c;
        do_start = ds;
        do_data  = dd;
        rom_dout = rw;
        @(posedge clk);
        #1;
        do_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (loop_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", loop_busy); end
        checks++; if (up_xcache !== 1'b0) begin errors++; $display("FAIL reset_xcache got %b want 0", up_xcache); end
        checks++; if (loop_halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", loop_halt); end
        checks++; if (do_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", do_err); end
        checks++; if (cache_dout !== 16'h0) begin errors++; $display("FAIL reset_dout got %h want 0000", cache_dout); end
        rst = 1'b0;
        model_n = 0;
    endtask

    // n==0 means redo; cen_mode 1 runs the pattern 1,0,0; inject_at is a slot index for an extra do_start
    task automatic run_loop(input string name, input int n, input int k, input int cen_mode, input int inject_at);
        logic [15:0] words [16];
        logic [15:0] exp_w, rw, p_dout;
        logic [3:0]  nn;
        logic [6:0]  kk;
        logic        c, pc, p_busy, p_x, ds, redo, done, fill;
        int          exp_busy, exp_x, busy_cnt, x_cnt, fill_idx;
        redo = (n == 0);
        nn = n[3:0];
        kk = k[6:0];
        busy_cnt = 0; x_cnt = 0; fill_idx = 0; done = 1'b0;
        if (!redo) begin
            for (int j = 0; j < n; j++) begin
                words[j] = 16'($urandom);
                model_cache[j] = words[j];
            end
            for (int p = 1; p < k; p++)
                for (int j = 0; j < n; j++) exp_q.push_back(words[j]);
            model_n  = n;
            exp_busy = n * k;
            exp_x    = n * (k - 1);
        end else begin
            for (int p = 0; p < k; p++)
                for (int j = 0; j < model_n; j++) exp_q.push_back(model_cache[j]);
            exp_busy = model_n * k;
            exp_x    = exp_busy;
        end
        pc = 1'b1; p_busy = 1'b0; p_x = 1'b0; p_dout = 16'h0;
        for (int i = 0; i < exp_busy * 3 + 10 && !done; i++) begin
            c = (cen_mode == 0) ? 1'b1 : (i % 3 == 0);
            if (i > 0) begin
                if (!pc) begin
                    checks++;
                    if ({loop_busy, up_xcache, cache_dout} !== {p_busy, p_x, p_dout}) begin
                        errors++;
                        $display("FAIL %s hold slot %0d got %b%b %h want %b%b %h", name, i,
                                 loop_busy, up_xcache, cache_dout, p_busy, p_x, p_dout);
                    end
                end
                checks++; if (loop_halt !== up_xcache) begin errors++; $display("FAIL %s halt slot %0d got %b want %b", name, i, loop_halt, up_xcache); end
                if (!up_xcache) begin
                    checks++; if (cache_dout !== 16'h0) begin errors++; $display("FAIL %s idle_dout slot %0d got %h want 0000", name, i, cache_dout); end
                end
                if (cen_mode == 0) begin
                    checks++;
                    if (do_err !== (inject_at >= 0 && i == inject_at + 1)) begin
                        errors++;
                        $display("FAIL %s err slot %0d got %b want %b", name, i, do_err, (inject_at >= 0 && i == inject_at + 1));
                    end
                end
                if (c && loop_busy) begin
                    busy_cnt++;
                    if (up_xcache) begin
                        x_cnt++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++; $display("FAIL %s dout slot %0d got %h want none", name, i, cache_dout);
                        end else begin
                            exp_w = exp_q.pop_front();
                            if (cache_dout !== exp_w) begin errors++; $display("FAIL %s dout slot %0d got %h want %h", name, i, cache_dout, exp_w); end
                        end
                    end else if (redo) begin
                        checks++; errors++;
                        $display("FAIL %s rom_slot slot %0d got xcache 0 want 1", name, i);
                    end
                end
                if (!loop_busy) done = 1'b1;
            end
            p_busy = loop_busy; p_x = up_xcache; p_dout = cache_dout; pc = c;
            if (!done) begin
                fill = (i > 0) && loop_busy && !up_xcache && fill_idx < 16;
                rw   = fill ? words[fill_idx] : 16'hFFFF;
                ds   = (i == 0) || (i == inject_at);
                tick(c, ds, (i == 0) ? {nn, kk} : {4'd2, 7'd2}, rw);
                if (c && fill) fill_idx++;
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL %s timeout got busy %b want 0", name, loop_busy); end
        checks++; if (busy_cnt != exp_busy) begin errors++; $display("FAIL %s busy_slots got %0d want %0d", name, busy_cnt, exp_busy); end
        checks++; if (x_cnt != exp_x) begin errors++; $display("FAIL %s replay_slots got %0d want %0d", name, x_cnt, exp_x); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL %s leftover got %0d want 0", name, exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic check_reject(input string name, input logic [10:0] dd);
        tick(1'b1, 1'b1, dd, 16'h0);
        checks++; if (do_err !== 1'b1) begin errors++; $display("FAIL %s err got %b want 1", name, do_err); end
        checks++; if (loop_busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b want 0", name, loop_busy); end
        tick(1'b1, 1'b0, 11'd0, 16'h0);
        checks++; if (do_err !== 1'b0) begin errors++; $display("FAIL %s err_clear got %b want 0", name, do_err); end
    endtask

    task automatic test_errors();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_n = 0;
        check_reject("redo_after_reset", {4'd0, 7'd2});
        check_reject("do_k0", {4'd3, 7'd0});
        tick(1'b1, 1'b1, {4'd4, 7'd5}, 16'h0);
        for (int j = 0; j < 4; j++) tick(1'b1, 1'b0, 11'd0, 16'($urandom));
        tick(1'b1, 1'b0, 11'd0, 16'hFFFF);
        checks++; if (up_xcache !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b want 1", up_xcache); end
        #2 rst = 1'b1;
        #1;
        checks++; if (loop_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", loop_busy); end
        checks++; if (loop_halt !== 1'b0) begin errors++; $display("FAIL midrst_halt got %b want 0", loop_halt); end
        checks++; if (up_xcache !== 1'b0) begin errors++; $display("FAIL midrst_xcache got %b want 0", up_xcache); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_n = 0;
        check_reject("redo_after_midrst", {4'd0, 7'd2});
    endtask

    initial begin
        test_reset();
        tick(1'b1, 1'b0, 11'd0, 16'h0);
        run_loop("do_n3_k2", 3, 2, 0, -1);
        run_loop("redo_k3", 0, 3, 0, -1);
        run_loop("do_n1_k1", 1, 1, 0, -1);
        run_loop("do_in_replay", 2, 3, 0, 4);
        run_loop("do_at_last_slot", 2, 2, 0, 4);
        run_loop("cen_toggle", 2, 3, 1, -1);
        run_loop("full_depth", 15, 2, 0, -1);
        run_loop("redo_full", 0, 2, 0, -1);
        test_errors();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
